// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - op-code definitions shared by the register bank and its entries
package regfile_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
  localparam logic [OP_W-1:0] OP_INC  = 3'b010;
  localparam logic [OP_W-1:0] OP_DEC  = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b101;
  localparam logic [OP_W-1:0] OP_CLR  = 3'b110;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

endpackage

// File: rtl/op_reg.sv
// rtl/op_reg.sv - single register entry with in-place op mux and sync-reset flop
module op_reg
  import regfile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             we,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] wdata,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             carry_nxt,
  output logic             zero_nxt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  always_comb begin
    w_res   = r_q;
    w_carry = 1'b0;
    case (op)
      OP_LOAD: w_res = wdata;
      OP_INC: begin
        w_res   = r_q + ONE;
        w_carry = &r_q;
      end
      OP_DEC: begin
        w_res   = r_q - ONE;
        w_carry = ~|r_q;
      end
      OP_SHL: begin
        w_res   = {r_q[WIDTH-2:0], sin};
        w_carry = r_q[WIDTH-1];
      end
      OP_SHR: begin
        w_res   = {sin, r_q[WIDTH-1:1]};
        w_carry = r_q[0];
      end
      OP_CLR:  w_res = '0;
      default: w_res = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_q <= '0;
    end else if (we) begin
      r_q <= w_res;
    end
  end

  assign q         = r_q;
  assign carry_nxt = w_carry;
  assign zero_nxt  = ~|w_res;

endmodule

// File: rtl/regfile_ops.sv
// rtl/regfile_ops.sv - DEPTH-entry register bank with in-place ops, two read ports and status flags
module regfile_ops
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              en,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              sin,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              carry,
  output logic              zero
);

  logic [WIDTH-1:0] w_q     [DEPTH];
  logic [DEPTH-1:0] w_carry;
  logic [DEPTH-1:0] w_zero;
  logic [DEPTH-1:0] w_sel;
  logic             w_op_act;
  logic             w_exec;
  logic             w_sel_carry;
  logic             w_sel_zero;
  logic             r_carry;
  logic             r_zero;

  // HOLD and the reserved code neither touch an entry nor the flags
  assign w_op_act = (op != OP_HOLD) && (op != OP_RSVD);

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_sel[g] = en && w_op_act && (waddr == ADDR_W'(g));

    op_reg #(.WIDTH(WIDTH)) u_entry (
      .clk       (clk),
      .rst_      (rst_),
      .we        (w_sel[g]),
      .op        (op),
      .wdata     (wdata),
      .sin       (sin),
      .q         (w_q[g]),
      .carry_nxt (w_carry[g]),
      .zero_nxt  (w_zero[g])
    );
  end

  // Out-of-range addresses match no entry, so they read 0 and never execute
  always_comb begin
    rdata_a     = '0;
    rdata_b     = '0;
    w_sel_carry = 1'b0;
    w_sel_zero  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) rdata_a = w_q[i];
      if (raddr_b == ADDR_W'(i)) rdata_b = w_q[i];
      if (waddr == ADDR_W'(i)) begin
        w_sel_carry = w_carry[i];
        w_sel_zero  = w_zero[i];
      end
    end
  end

  assign w_exec = |w_sel;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_exec) begin
      r_carry <= w_sel_carry;
      r_zero  <= w_sel_zero;
    end
  end

  assign carry = r_carry;
  assign zero  = r_zero;

endmodule

// File: tb/tb_regfile_ops.sv
// tb/tb_regfile_ops.sv - directed self-checking bench for regfile_ops (DEPTH=4 and DEPTH=3)
module tb_regfile_ops;
  import regfile_pkg::*;

  logic       clk;
  logic       rst_;
  logic       en;
  logic [2:0] op;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       sin;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic [7:0] rdata_a4, rdata_b4, rdata_a3, rdata_b3;
  logic       carry4, zero4, carry3, zero3;

  int vectors;
  int miscompares;

  regfile_ops #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_(rst_), .en(en), .op(op), .waddr(waddr), .wdata(wdata), .sin(sin),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a4), .rdata_b(rdata_b4),
    .carry(carry4), .zero(zero4)
  );

  regfile_ops #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_(rst_), .en(en), .op(op), .waddr(waddr), .wdata(wdata), .sin(sin),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a3), .rdata_b(rdata_b3),
    .carry(carry3), .zero(zero3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] o, input logic [1:0] a,
                       input logic [7:0] d, input logic s);
    en = e; op = o; waddr = a; wdata = d; sin = s;
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] b);
    raddr_a = a;
    raddr_b = b;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_ = 1'b0;
    drive(1'b1, OP_LOAD, 2'd0, 8'hFF, 1'b0);
    raddr_a = 2'd0;
    raddr_b = 2'd1;

    // reset edge with a LOAD presented: must be discarded
    tick();
    rst_ = 1'b1;
    en   = 1'b0;
    rd(2'd0, 2'd1);
    chk("rst_e0", rdata_a4, 8'h00);
    chk("rst_e1", rdata_b4, 8'h00);
    rd(2'd2, 2'd3);
    chk("rst_e2", rdata_a4, 8'h00);
    chk("rst_e3", rdata_b4, 8'h00);
    chk("rst_carry", carry4, 1'b0);
    chk("rst_zero", zero4, 1'b0);

    // LOAD A5 to e2, no bypass on the same-cycle read
    drive(1'b1, OP_LOAD, 2'd2, 8'hA5, 1'b0);
    rd(2'd2, 2'd1);
    chk("load_same_cycle", rdata_a4, 8'h00);
    tick();
    en = 1'b0;
    chk("load_rd_a", rdata_a4, 8'hA5);
    chk("load_rd_b", rdata_b4, 8'h00);
    chk("load_zero", zero4, 1'b0);
    chk("load_carry", carry4, 1'b0);

    // INC/DEC wrap on e3
    rd(2'd3, 2'd2);
    drive(1'b1, OP_LOAD, 2'd3, 8'hFF, 1'b0);
    tick();
    chk("e3_ff", rdata_a4, 8'hFF);
    op = OP_INC;
    tick();
    chk("inc_wrap_val", rdata_a4, 8'h00);
    chk("inc_wrap_carry", carry4, 1'b1);
    chk("inc_wrap_zero", zero4, 1'b1);
    op = OP_DEC;
    tick();
    chk("dec_wrap_val", rdata_a4, 8'hFF);
    chk("dec_wrap_carry", carry4, 1'b1);
    chk("dec_wrap_zero", zero4, 1'b0);
    tick();
    chk("dec_val", rdata_a4, 8'hFE);
    chk("dec_carry", carry4, 1'b0);
    chk("dec_other_e2", rdata_b4, 8'hA5);

    // shifts and clear on e0
    rd(2'd0, 2'd3);
    drive(1'b1, OP_LOAD, 2'd0, 8'h81, 1'b0);
    tick();
    drive(1'b1, OP_SHL, 2'd0, 8'h00, 1'b1);
    tick();
    chk("shl_val", rdata_a4, 8'h03);
    chk("shl_carry", carry4, 1'b1);
    drive(1'b1, OP_SHR, 2'd0, 8'h00, 1'b0);
    tick();
    chk("shr_val", rdata_a4, 8'h01);
    chk("shr_carry", carry4, 1'b1);
    chk("shr_zero", zero4, 1'b0);
    op = OP_CLR;
    tick();
    chk("clr_val", rdata_a4, 8'h00);
    chk("clr_zero", zero4, 1'b1);
    chk("clr_carry", carry4, 1'b0);
    chk("clr_other_e3", rdata_b4, 8'hFE);

    // en=0 with INC, then reserved op with en=1: nothing moves
    rd(2'd2, 2'd3);
    drive(1'b0, OP_INC, 2'd2, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en0_e2", rdata_a4, 8'hA5);
      chk("en0_zero", zero4, 1'b1);
      chk("en0_carry", carry4, 1'b0);
    end
    drive(1'b1, OP_RSVD, 2'd3, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rsvd_e3", rdata_b4, 8'hFE);
      chk("rsvd_zero", zero4, 1'b1);
      chk("rsvd_carry", carry4, 1'b0);
    end
    op = OP_HOLD;
    tick();
    chk("hold_e2", rdata_a4, 8'hA5);
    chk("hold_zero", zero4, 1'b1);

    // DEPTH=3: out-of-range write ignored, out-of-range read is zero
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    drive(1'b1, OP_LOAD, 2'd1, 8'h77, 1'b0);
    tick();
    drive(1'b1, OP_LOAD, 2'd3, 8'h00, 1'b0);
    tick();
    en = 1'b0;
    rd(2'd1, 2'd3);
    chk("d3_e1", rdata_a3, 8'h77);
    chk("d3_oob_rd", rdata_b3, 8'h00);
    chk("d3_oob_zero", zero3, 1'b0);
    chk("d4_e3_zero", zero4, 1'b1);
    drive(1'b1, OP_LOAD, 2'd3, 8'h3C, 1'b0);
    tick();
    en = 1'b0;
    chk("d3_oob_rd2", rdata_b3, 8'h00);
    chk("d4_e3_load", rdata_b4, 8'h3C);

    // reset in the middle of an INC burst on e0
    rd(2'd0, 2'd1);
    drive(1'b1, OP_INC, 2'd0, 8'h00, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("burst_d3", rdata_a3, 32'(i));
      chk("burst_d4", rdata_a4, 32'(i));
    end
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    chk("midrst_e0", rdata_a3, 8'h00);
    chk("midrst_e1", rdata_b3, 8'h00);
    chk("midrst_carry", carry3, 1'b0);
    chk("midrst_zero", zero3, 1'b0);
    tick();
    en = 1'b0;
    chk("post_rst_inc", rdata_a3, 8'h01);
    chk("post_rst_zero", zero3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
